// File: rtl/log_readout_ctrl.sv
// Readout sequencer for double-buffered log PEs: after each CGRA sync it walks the masked
// logs in ascending order, reads LEN words from each and streams them out via a 2-entry FIFO.
module log_readout_ctrl #(
  parameter int unsigned NUM_LOGS       = 4,
  parameter int unsigned LOG_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                           CGRA_CLK_I,
  input  logic                           RST_I,
  input  logic                           EN_I,
  input  logic                           SYNC_IN_I,
  input  logic [LOG_ADDR_WIDTH:0]        LOG_LEN_I,
  input  logic [NUM_LOGS-1:0]            LOG_MASK_I,
  output logic [LOG_ADDR_WIDTH-1:0]      LOG_READ_ADDR_O,
  output logic [NUM_LOGS-1:0]            LOG_READ_EN_O,
  input  logic [NUM_LOGS*DATA_WIDTH-1:0] LOG_DATA_I,
  output logic [DATA_WIDTH-1:0]          M_DATA_O,
  output logic                           M_LAST_O,
  output logic                           M_VALID_O,
  input  logic                           M_READY_I,
  output logic                           LOG_TRANSACTIONS_DONE_O,
  output logic                           BUSY_O,
  output logic                           OVERRUN_O,
  input  logic                           CLEAR_OVERRUN_I
);

  localparam int unsigned IdxW = (NUM_LOGS > 1) ? $clog2(NUM_LOGS) : 1;
  localparam int unsigned AW   = LOG_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                  state_q;
  logic                    primed_q;
  logic                    overrun_q;
  logic [AW-1:0]           len_q;
  logic [AW-1:0]           addr_q;
  logic [NUM_LOGS-1:0]     mask_q;
  logic [IdxW-1:0]         idx_q;
  logic                    inflight_q;
  logic                    inflight_last_q;
  logic [IdxW-1:0]         inflight_idx_q;
  logic [DATA_WIDTH-1:0]   fifo_data_q [2];
  logic [1:0]              fifo_last_q;
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [1:0]              count_q;

  logic                    pop;
  logic                    push;
  logic                    issue;
  logic                    empty_xfer;
  logic                    last_addr;
  logic                    has_next;
  logic                    start;
  logic [2:0]              occupancy;
  logic [IdxW-1:0]         first_idx;
  logic [IdxW-1:0]         next_idx;
  logic [DATA_WIDTH-1:0]   cap_data;

  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    cap_data  = '0;
    // Descending scans so the lowest qualifying index wins.
    for (int i = NUM_LOGS - 1; i >= 0; i--) begin
      if (LOG_MASK_I[i]) first_idx = IdxW'(i);
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_idx = IdxW'(i);
        has_next = 1'b1;
      end
      if (inflight_idx_q == IdxW'(i)) cap_data = LOG_DATA_I[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    pop        = M_VALID_O & M_READY_I;
    push       = inflight_q & EN_I;
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    empty_xfer = (len_q == '0) || (mask_q == '0);
    last_addr  = (addr_q == (len_q - AW'(1)));
    issue      = EN_I && (state_q == StRead) && !empty_xfer && (occupancy < 3'd2);
    start      = EN_I && SYNC_IN_I && primed_q && ((state_q == StIdle) || (state_q == StDone));

    LOG_READ_EN_O = '0;
    if (issue) LOG_READ_EN_O[idx_q] = 1'b1;
    LOG_READ_ADDR_O         = addr_q[LOG_ADDR_WIDTH-1:0];
    M_VALID_O               = (count_q != 2'd0);
    M_DATA_O                = fifo_data_q[rd_ptr_q];
    M_LAST_O                = M_VALID_O & fifo_last_q[rd_ptr_q];
    LOG_TRANSACTIONS_DONE_O = (state_q == StDone);
    BUSY_O                  = (state_q != StIdle);
    OVERRUN_O               = overrun_q;
  end

  always_ff @(posedge CGRA_CLK_I) begin
    if (RST_I) begin
      state_q         <= StIdle;
      primed_q        <= 1'b0;
      overrun_q       <= 1'b0;
      len_q           <= '0;
      addr_q          <= '0;
      mask_q          <= '0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_idx_q  <= '0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      // The stream side keeps draining even while disabled.
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= cap_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      if (EN_I) begin
        inflight_q <= issue;
        if (issue) begin
          inflight_idx_q  <= idx_q;
          inflight_last_q <= last_addr && !has_next;
        end

        if (SYNC_IN_I && ((state_q == StRead) || (state_q == StDrain))) overrun_q <= 1'b1;
        else if (CLEAR_OVERRUN_I)                                       overrun_q <= 1'b0;

        if (start) begin
          state_q <= StRead;
          len_q   <= LOG_LEN_I;
          mask_q  <= LOG_MASK_I;
          idx_q   <= first_idx;
          addr_q  <= '0;
        end else begin
          unique case (state_q)
            StIdle: if (SYNC_IN_I) primed_q <= 1'b1;
            StRead: begin
              if (empty_xfer) begin
                state_q <= StDone;
              end else if (issue) begin
                if (!last_addr) begin
                  addr_q <= addr_q + AW'(1);
                end else if (has_next) begin
                  idx_q  <= next_idx;
                  addr_q <= '0;
                end else begin
                  state_q <= StDrain;
                end
              end
            end
            // Leave as soon as the final word is being accepted.
            StDrain: begin
              if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                state_q <= StDone;
              end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_log_readout_ctrl.sv
// Directed bench for log_readout_ctrl: a cycle table for the basic readout plus
// scoreboarded sequences for stalls, empty transactions, overrun, enable gaps and reset.
module tb_log_readout_ctrl;

  logic         clk;
  logic         RST_I;
  logic         EN_I;
  logic         SYNC_IN_I;
  logic [8:0]   LOG_LEN_I;
  logic [3:0]   LOG_MASK_I;
  logic [7:0]   LOG_READ_ADDR_O;
  logic [3:0]   LOG_READ_EN_O;
  logic [127:0] LOG_DATA_I;
  logic [31:0]  M_DATA_O;
  logic         M_LAST_O;
  logic         M_VALID_O;
  logic         M_READY_I;
  logic         LOG_TRANSACTIONS_DONE_O;
  logic         BUSY_O;
  logic         OVERRUN_O;
  logic         CLEAR_OVERRUN_I;

  log_readout_ctrl #(
    .NUM_LOGS      (4),
    .LOG_ADDR_WIDTH(8),
    .DATA_WIDTH    (32)
  ) dut (
    .CGRA_CLK_I             (clk),
    .RST_I                  (RST_I),
    .EN_I                   (EN_I),
    .SYNC_IN_I              (SYNC_IN_I),
    .LOG_LEN_I              (LOG_LEN_I),
    .LOG_MASK_I             (LOG_MASK_I),
    .LOG_READ_ADDR_O        (LOG_READ_ADDR_O),
    .LOG_READ_EN_O          (LOG_READ_EN_O),
    .LOG_DATA_I             (LOG_DATA_I),
    .M_DATA_O               (M_DATA_O),
    .M_LAST_O               (M_LAST_O),
    .M_VALID_O              (M_VALID_O),
    .M_READY_I              (M_READY_I),
    .LOG_TRANSACTIONS_DONE_O(LOG_TRANSACTIONS_DONE_O),
    .BUSY_O                 (BUSY_O),
    .OVERRUN_O              (OVERRUN_O),
    .CLEAR_OVERRUN_I        (CLEAR_OVERRUN_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i, input int a);
    return 32'hD000_0000 | (32'(i) << 8) | 32'(a);
  endfunction

  // Log PE model: registered read data, one cycle after the enable.
  logic [31:0] pe_data [4];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (LOG_READ_EN_O[i]) pe_data[i] <= word(i, int'(LOG_READ_ADDR_O));
    end
  end
  always_comb begin
    LOG_DATA_I = '0;
    for (int i = 0; i < 4; i++) LOG_DATA_I[i*32 +: 32] = pe_data[i];
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          n_iss = 0;
  int          n_pop = 0;
  int          n_done = 0;
  logic [31:0] word_q[$];
  logic [31:0] iss_q[$];
  logic        stall = 1'b0;
  logic [31:0] held = '0;
  logic        tog_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One monitored cycle: inputs already driven; checks, then advance to next negedge.
  task automatic cyc();
    logic [31:0] w;
    #1;
    if (LOG_READ_EN_O != 4'b0) begin
      n_iss++;
      chk("read_gated", {31'b0, EN_I}, 1);
      chk("read_expected", 32'(iss_q.size() != 0), 1);
      if (iss_q.size() != 0) begin
        w = iss_q.pop_front();
        chk("read_en", 32'(LOG_READ_EN_O), 32'd1 << w[11:8]);
        chk("read_addr", 32'(LOG_READ_ADDR_O), 32'(w[7:0]));
      end
    end
    if (stall) begin
      chk("hold_valid", 32'(M_VALID_O), 1);
      chk("hold_data", M_DATA_O, held);
    end
    if (M_VALID_O && M_READY_I) begin
      n_pop++;
      chk("word_expected", 32'(word_q.size() != 0), 1);
      if (word_q.size() != 0) begin
        w = word_q.pop_front();
        chk("data", M_DATA_O, w);
        chk("last", 32'(M_LAST_O), 32'(word_q.size() == 0));
      end
    end
    stall = M_VALID_O && !M_READY_I;
    held  = M_DATA_O;
    chk("outstanding", 32'((n_iss - n_pop) <= 2), 1);
    if (LOG_TRANSACTIONS_DONE_O) n_done++;
    @(negedge clk);
    if (tog_ready) M_READY_I = !M_READY_I;
  endtask

  task automatic start_xfer(input logic [3:0] mask, input int len);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        for (int a = 0; a < len; a++) begin
          word_q.push_back(word(i, a));
          iss_q.push_back(word(i, a));
        end
      end
    end
    LOG_MASK_I = mask;
    LOG_LEN_I  = 9'(len);
    SYNC_IN_I  = 1'b1;
    cyc();
    SYNC_IN_I  = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin
      cyc();
      k++;
    end
    chk("done_seen", 32'(n_done - d0), 1);
    chk("words_left", 32'(word_q.size()), 0);
    chk("reads_left", 32'(iss_q.size()), 0);
    #1;
    chk("done_one_cycle", 32'(LOG_TRANSACTIONS_DONE_O), 0);
  endtask

  typedef struct {
    logic        sync;
    logic [3:0]  ren;
    logic [7:0]  addr;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int base;
    int k;
    int d0;

    RST_I = 1'b1; EN_I = 1'b1; SYNC_IN_I = 1'b0; LOG_LEN_I = '0; LOG_MASK_I = '0;
    M_READY_I = 1'b1; CLEAR_OVERRUN_I = 1'b0;
    repeat (2) @(negedge clk);
    RST_I = 1'b0;
    #1;
    chk("reset_outputs", {20'b0, LOG_READ_EN_O, M_VALID_O, M_LAST_O, LOG_TRANSACTIONS_DONE_O,
                          BUSY_O, OVERRUN_O, 3'b0}, 0);
    chk("reset_data", M_DATA_O, 0);

    // Prime, start, then PE0 and PE2 at three words each with ready held high.
    tbl[0]  = '{1'b1, 4'h0, 8'd0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 8'd0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'h0, 8'd0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'h1, 8'd0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'h1, 8'd1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'h1, 8'd2, 1'b1, word(0,0), 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'h4, 8'd0, 1'b1, word(0,1), 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'h4, 8'd1, 1'b1, word(0,2), 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'h4, 8'd2, 1'b1, word(2,0), 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 8'd0, 1'b1, word(2,1), 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 8'd0, 1'b1, word(2,2), 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 8'd0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 8'd0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0};
    LOG_MASK_I = 4'b0101;
    LOG_LEN_I  = 9'd3;
    for (int v = 0; v < 13; v++) begin
      SYNC_IN_I = tbl[v].sync;
      #1;
      chk($sformatf("v%0d_ren", v), 32'(LOG_READ_EN_O), 32'(tbl[v].ren));
      if (tbl[v].ren != 4'h0) chk($sformatf("v%0d_addr", v), 32'(LOG_READ_ADDR_O), 32'(tbl[v].addr));
      chk($sformatf("v%0d_valid", v), 32'(M_VALID_O), 32'(tbl[v].valid));
      if (tbl[v].valid) chk($sformatf("v%0d_data", v), M_DATA_O, tbl[v].data);
      chk($sformatf("v%0d_last", v), 32'(M_LAST_O), 32'(tbl[v].last));
      chk($sformatf("v%0d_done", v), 32'(LOG_TRANSACTIONS_DONE_O), 32'(tbl[v].done));
      chk($sformatf("v%0d_busy", v), 32'(BUSY_O), 32'(tbl[v].busy));
      @(negedge clk);
    end
    SYNC_IN_I = 1'b0;

    // Empty transactions: LEN=0, then mask=0.
    for (int t = 0; t < 2; t++) begin
      LOG_LEN_I  = (t == 0) ? 9'd0 : 9'd4;
      LOG_MASK_I = (t == 0) ? 4'hF : 4'h0;
      SYNC_IN_I  = 1'b1;
      cyc();
      SYNC_IN_I  = 1'b0;
      #1;
      chk("empty_busy", 32'(BUSY_O), 1);
      chk("empty_early_done", 32'(LOG_TRANSACTIONS_DONE_O), 0);
      cyc();
      #1;
      chk("empty_done", 32'(LOG_TRANSACTIONS_DONE_O), 1);
      chk("empty_valid", 32'(M_VALID_O), 0);
      cyc();
      #1;
      chk("empty_done_once", 32'(LOG_TRANSACTIONS_DONE_O), 0);
      chk("empty_idle", 32'(BUSY_O), 0);
    end

    // All four logs, four words each, with ready toggling.
    tog_ready = 1'b1;
    start_xfer(4'hF, 4);
    run_until_done(200);
    tog_ready = 1'b0;
    M_READY_I = 1'b1;
    cyc();

    // Overrun: sticky, and set beats clear.
    start_xfer(4'hF, 4);
    repeat (3) cyc();
    SYNC_IN_I = 1'b1;
    cyc();
    SYNC_IN_I = 1'b0;
    #1;
    chk("overrun_set", 32'(OVERRUN_O), 1);
    run_until_done(100);
    cyc();
    #1;
    chk("overrun_sticky", 32'(OVERRUN_O), 1);
    CLEAR_OVERRUN_I = 1'b1;
    cyc();
    CLEAR_OVERRUN_I = 1'b0;
    #1;
    chk("overrun_cleared", 32'(OVERRUN_O), 0);
    start_xfer(4'hF, 4);
    repeat (3) cyc();
    SYNC_IN_I = 1'b1;
    CLEAR_OVERRUN_I = 1'b1;
    cyc();
    SYNC_IN_I = 1'b0;
    CLEAR_OVERRUN_I = 1'b0;
    #1;
    chk("overrun_set_wins", 32'(OVERRUN_O), 1);
    run_until_done(100);
    CLEAR_OVERRUN_I = 1'b1;
    cyc();
    CLEAR_OVERRUN_I = 1'b0;

    // Enable gap of three cycles mid-read.
    start_xfer(4'h1, 8);
    base = n_iss;
    k = 0;
    while ((n_iss - base) < 3 && k < 20) begin
      cyc();
      k++;
    end
    EN_I = 1'b0;
    repeat (3) begin
      #1;
      chk("gap_ren", 32'(LOG_READ_EN_O), 0);
      cyc();
    end
    EN_I = 1'b1;
    run_until_done(60);

    // Reset after two of eight words.
    start_xfer(4'h3, 4);
    base = n_pop;
    k = 0;
    while ((n_pop - base) < 2 && k < 30) begin
      cyc();
      k++;
    end
    RST_I = 1'b1;
    cyc();
    RST_I = 1'b0;
    word_q.delete();
    iss_q.delete();
    stall = 1'b0;
    n_iss = 0;
    n_pop = 0;
    d0 = n_done;
    #1;
    chk("rst_valid", 32'(M_VALID_O), 0);
    chk("rst_idle", 32'(BUSY_O), 0);
    repeat (4) cyc();
    chk("rst_no_done", 32'(n_done - d0), 0);

    // After reset the first sync only primes.
    LOG_MASK_I = 4'hF;
    LOG_LEN_I  = 9'd4;
    SYNC_IN_I  = 1'b1;
    cyc();
    SYNC_IN_I  = 1'b0;
    repeat (3) begin
      #1;
      chk("prime_only_busy", 32'(BUSY_O), 0);
      cyc();
    end
    chk("prime_only_done", 32'(n_done - d0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/log_readout_ctrl.md
Name: log_readout_ctrl

Overview:
Sequencer that drains the read-side buffers of up to NUM_LOGS double-buffered log PEs after each CGRA sync. It issues per-PE read enables and addresses, and muxes the returned data into a single valid/ready word stream. When a transaction finishes it pulses a one-cycle transactions-done signal that flips the PEs' read buffers. It sits between the log PE array and the host-side transfer logic.

Parameters:
NUM_LOGS, 4, number of log PEs served (1..16)
LOG_ADDR_WIDTH, 8, log PE read address width
DATA_WIDTH, 32, log word width

Ports:
CGRA_CLK_I  in  1  clock
RST_I  in  1  synchronous active-high reset
EN_I  in  1  global enable; also gates log PE reads
SYNC_IN_I  in  1  CGRA sync pulse; swaps log PE write buffers
LOG_LEN_I  in  LOG_ADDR_WIDTH+1  words per log; sampled at transaction start
LOG_MASK_I  in  NUM_LOGS  logs included in readout; sampled at start
LOG_READ_ADDR_O  out  LOG_ADDR_WIDTH  shared read address to all log PEs
LOG_READ_EN_O  out  NUM_LOGS  one-hot read enable
LOG_DATA_I  in  NUM_LOGS*DATA_WIDTH  concatenated log PE read data; PE i at slice i
M_DATA_O  out  DATA_WIDTH  stream data
M_LAST_O  out  1  final word of transaction
M_VALID_O  out  1  stream valid
M_READY_I  in  1  stream ready
LOG_TRANSACTIONS_DONE_O  out  1  one-cycle done pulse to log PEs
BUSY_O  out  1  state != IDLE
OVERRUN_O  out  1  sticky: sync arrived while busy
CLEAR_OVERRUN_I  in  1  clears OVERRUN_O

Behaviour:
- Reset: state IDLE, primed=0, FIFO empty, in-flight=0. All outputs are 0.
- primed flag: the first SYNC_IN_I after reset only sets primed=1 and starts nothing, because that buffer is still being filled. Each later SYNC_IN_I in IDLE starts a transaction.
- EN_I=0: no state, counter, FIFO-load or flag updates, and no read is issued (LOG_READ_EN_O=0). The stream side still pops; M_VALID_O and M_DATA_O track the FIFO head.
- States: IDLE, READ, DRAIN, DONE.
- IDLE + start: latch LOG_LEN_I and LOG_MASK_I; log index = lowest set mask bit; addr=0.
  - Goes to READ.
  - If LEN=0 or mask=0, goes straight to DONE; no words are emitted.
- READ: a read is issued in a cycle when (fifo_count + inflight − pop) < 2, where pop = M_VALID_O & M_READY_I.
  - Issue means LOG_READ_EN_O[idx]=1 and LOG_READ_ADDR_O=addr, both combinational from state.
  - Sustained throughput is 1 word/cycle while M_READY_I=1.
- Read latency: exactly 1 cycle. Data is captured from slice idx of LOG_DATA_I on the cycle after issue, into a 2-entry FIFO; the captured index is pipelined with the read.
- Order: addr 0..LEN−1 for each masked log, logs in ascending index. After addr=LEN−1, move to the next set mask bit with addr=0.
- After the last read is issued, go to DRAIN. The last word carries M_LAST_O=1 at the FIFO head.
- DRAIN: wait until in-flight=0 and the last word is popped, then go to DONE.
- DONE: LOG_TRANSACTIONS_DONE_O=1 for exactly one cycle, then IDLE.
- Stream: M_DATA_O and M_VALID_O come from the FIFO head. Once M_VALID_O is high, data is held stable until accepted.
- SYNC_IN_I during READ or DRAIN: OVERRUN_O set to 1. The transaction continues and that sync is dropped.
- SYNC_IN_I in the DONE cycle: starts the next transaction; the state goes DONE→READ with normal start latching, and no overrun is flagged.
- CLEAR_OVERRUN_I together with a new overrun: set wins.
- Reset mid-transaction: immediate return to IDLE; FIFO flushed; primed=0; no done pulse.
- Width rules: addr counter is LOG_ADDR_WIDTH+1 bits; compare is against LEN−1; LEN is limited to at most 2^LOG_ADDR_WIDTH.

Test Plan:
- Reset, sync, sync, mask=4'b0101, LEN=3, ready=1 → reads PE0 addr 0,1,2 then PE2 addr 0,1,2. Six words emitted in consecutive cycles, M_LAST_O on the 6th, done pulse 1 cycle after the last pop.
- First sync after reset only → BUSY_O stays 0, no reads, no done pulse.
- Mask=4'b1111, LEN=4, M_READY_I toggling 1/0 → 16 words in order, none lost or duplicated, data stable while valid&!ready, never more than 2 words buffered.
- LEN=0, or mask=0, on start → no read enable, done pulse on the 2nd cycle after the start sync, M_VALID_O stays 0.
- Sync mid-READ → OVERRUN_O=1 and stays set after the transaction. CLEAR_OVERRUN_I in the same cycle as another mid-READ sync → OVERRUN_O stays 1.
- RST_I asserted after 2 of 8 words → M_VALID_O=0 next cycle, state IDLE, no done pulse.
- EN_I low for 3 cycles mid-READ → no read enables during the gap, sequence resumes at the next address.
